ram_line_arbiter: RTL

Round-robin arbiter that shares the single line-fill RAM port among up to NUM_REQ cache miss requesters (I-cache, D-cache, prefetcher, etc.). It sits between the cache controllers and `ram`. It serialises fill requests and issues a one-cycle request pulse with a stable address to the RAM. It returns the 512-bit line to the granted requester only, and flags fills that exceed a watchdog limit.

---
 rtl/ram_line_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ram_line_arbiter.sv
// ram_line_arbiter
//
// Round-robin arbiter that shares the single line-fill RAM port among up to
// NUM_REQ cache miss requesters. One fill is in flight at a time: the winner's
// address is latched, a one-cycle ram_req pulse is issued, and the returned
// line is forwarded only to the granted requester. A watchdog turns a missing
// ram_ready into an error response. The arbiter then waits for the late
// completion before it issues anything else.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   req_valid    per-requester fill request (level, held until its resp_valid)
//   req_addr     flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   resp_valid   one-cycle pulse to the served requester
//   resp_err     qualifies resp_valid: fill timed out, resp_data is zero
//   resp_data    returned line, valid with resp_valid
//   grant_id     index of the requester currently being served
//   busy         high whenever the arbiter is not idle
//   ram_req      one-cycle request pulse to the RAM
//   ram_address  address to the RAM, held from issue through completion
//   ram_data     line from the RAM, sampled on ram_ready
//   ram_ready    RAM completion pulse
module ram_line_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_err,
  output logic [LINE_W-1:0]         resp_data,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      ram_req,
  output logic [ADDR_W-1:0]         ram_address,
  input  logic [LINE_W-1:0]         ram_data,
  input  logic                      ram_ready
);

  // The watchdog counter is 8 bits wide, so TIMEOUT must stay within 1..255.
  localparam logic [7:0]         TIMEOUT_8 = 8'(TIMEOUT);
  localparam logic [3:0]         NUM_REQ_4 = 4'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t               state;
  state_t               state_next;
  logic [2:0]           rr_ptr;
  logic [7:0]           cnt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [3:0]           offset;
  logic [3:0]           cand;
  logic [2:0]           pick;
  logic [ADDR_W-1:0]    sel_addr;
  logic [3:0]           rr_inc;
  logic [2:0]           rr_next;
  logic                 timeout_hit;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl  = {req_valid, req_valid};
    req_rot  = NUM_REQ'(req_dbl >> rr_ptr);
    found    = |req_rot;
    offset   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = 4'(k);
      end
    end
    cand = {1'b0, rr_ptr} + offset;
    if (cand >= NUM_REQ_4) begin
      cand = cand - NUM_REQ_4;
    end
    pick     = cand[2:0];
    sel_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (cand == 4'(j)) begin
        sel_addr = req_addr[j*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    rr_inc  = {1'b0, grant_id} + 4'd1;
    rr_next = (rr_inc >= NUM_REQ_4) ? 3'd0 : rr_inc[2:0];
  end

  // ram_ready wins over the watchdog when both land in the same cycle.
  assign timeout_hit = (state == WAIT) && !ram_ready && (cnt == TIMEOUT_8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (ram_ready || cnt == TIMEOUT_8) state_next = RESP;
      // After a timeout the RAM still owes a completion; hold off new issues.
      RESP:    state_next = resp_err ? DRAIN : IDLE;
      DRAIN:   if (ram_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs are registered from the next-state decode, so they line up
  // with the state they describe and have no path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      ram_req     <= 1'b0;
      ram_address <= '0;
      resp_valid  <= '0;
      resp_err    <= 1'b0;
      resp_data   <= '0;
      cnt         <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      ram_req    <= (state_next == ISSUE);
      resp_valid <= (state_next == RESP) ? (ONE_HOT0 << grant_id) : '0;
      resp_err   <= timeout_hit;

      // The address is captured once at grant; later req_addr changes are
      // ignored because the RAM samples ram_address at completion.
      if (state == IDLE && found) begin
        grant_id    <= pick;
        ram_address <= sel_addr;
      end

      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && cnt != TIMEOUT_8) begin
        cnt <= cnt + 8'd1;
      end

      if (state == WAIT) begin
        if (ram_ready) begin
          resp_data <= ram_data;
        end else if (cnt == TIMEOUT_8) begin
          resp_data <= '0;
        end
      end

      if (state == RESP) begin
        rr_ptr <= rr_next;
      end
    end
  end

endmodule
